// File: rtl/pc_lut_pkg.sv
// Shared definitions for the programmable jump-target table: default sizes,
// loader FSM encoding and the power-on target image.
package pc_lut_pkg;

  localparam int DEF_D = 12;
  localparam int DEF_A = 4;

  typedef enum logic [1:0] {
    IDX    = 2'd0,
    HI     = 2'd1,
    LO     = 2'd2,
    COMMIT = 2'd3
  } pc_lut_state_e;

  // Plain vector copies of the state encoding for code that keeps state in logic.
  localparam logic [1:0] ST_IDX    = IDX;
  localparam logic [1:0] ST_HI     = HI;
  localparam logic [1:0] ST_LO     = LO;
  localparam logic [1:0] ST_COMMIT = COMMIT;

  localparam int IMAGE_LEN = 4;
  localparam logic [15:0] POWER_ON_IMAGE [IMAGE_LEN] = '{16'd13, 16'd25, 16'd37, 16'd49};

  // Entries beyond the explicit image come up as zero.
  function automatic logic [15:0] image_entry(input int idx);
    if (idx >= 0 && idx < IMAGE_LEN) return POWER_ON_IMAGE[idx[1:0]];
    return 16'd0;
  endfunction

endpackage

// File: rtl/pc_lut_if.sv
// Byte-stream loader handshake between the boot/debug loader and the table writer.
interface pc_lut_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pc_lut_regfile.sv
// Jump-target storage: one synchronous write port, combinational read,
// asynchronous reset back to the power-on image.
module pc_lut_regfile
  import pc_lut_pkg::*;
#(
  parameter int D = DEF_D,
  parameter int A = DEF_A
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [D-1:0] wdata,
  input  logic [A-1:0] raddr,
  output logic [D-1:0] rdata
);

  logic [D-1:0] mem [2**A];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**A; i++) begin
        mem[i] <= D'(image_entry(i));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // No write bypass: a read of the committing entry sees the old value.
  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_lut_writer.sv
// Loader FSM that assembles three-byte records (index, target high, target low),
// rejects records with stray high bits, and commits good ones into the table.
module pc_lut_writer
  import pc_lut_pkg::*;
#(
  parameter int D = DEF_D,
  parameter int A = DEF_A
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_lut_if.slave      ld,
  input  logic         clr_err,
  input  logic [A-1:0] addr,
  output logic [D-1:0] target,
  output logic         wr_done,
  output logic         err
);

  logic [1:0]   state;
  logic [A-1:0] idx_q;
  logic [D-9:0] hi_q;
  logic [7:0]   lo_q;
  logic         bad_q;
  logic         xfer;
  logic         idx_bad;
  logic         hi_bad;
  logic         commit_we;

  assign ld.ready  = (state != ST_COMMIT);
  assign xfer      = ld.valid && ld.ready;
  assign idx_bad   = (ld.data >> A) != 8'd0;
  assign hi_bad    = (ld.data >> (D - 8)) != 8'd0;
  assign commit_we = (state == ST_COMMIT) && !bad_q;
  assign wr_done   = commit_we;

  // A malformed record is still consumed byte for byte so framing stays aligned;
  // bad_q remembers any must-be-zero violation until the commit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDX;
      idx_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      bad_q <= 1'b0;
    end else begin
      case (state)
        ST_IDX: begin
          if (xfer) begin
            idx_q <= ld.data[A-1:0];
            bad_q <= idx_bad;
            state <= ST_HI;
          end
        end
        ST_HI: begin
          if (xfer) begin
            hi_q  <= ld.data[D-9:0];
            bad_q <= bad_q | hi_bad;
            state <= ST_LO;
          end
        end
        ST_LO: begin
          if (xfer) begin
            lo_q  <= ld.data;
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: state <= ST_IDX;
        default:   state <= ST_IDX;
      endcase
    end
  end

  // Setting takes priority over clearing when both land in the same commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((state == ST_COMMIT) && bad_q) begin
      err <= 1'b1;
    end else if (clr_err) begin
      err <= 1'b0;
    end
  end

  pc_lut_regfile #(
    .D(D),
    .A(A)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit_we),
    .waddr (idx_q),
    .wdata ({hi_q, lo_q}),
    .raddr (addr),
    .rdata (target)
  );

endmodule

// File: tb/tb_pc_lut_writer.sv
// Self-checking bench for pc_lut_writer: directed scenarios plus randomized
// records checked against a record-level model of the table and error flag.
module tb_pc_lut_writer;

  localparam int D = 12;
  localparam int A = 4;
  localparam int N = 16;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b1;
  logic         clr_err = 1'b0;
  logic [A-1:0] addr    = '0;
  logic [D-1:0] target;
  logic         wr_done;
  logic         err;

  int errors = 0;
  int checks = 0;
  int done_count = 0;

  int unsigned model [N];
  bit          err_m;

  pc_lut_if ld ();

  pc_lut_writer #(
    .D(D),
    .A(A)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (ld),
    .clr_err (clr_err),
    .addr    (addr),
    .target  (target),
    .wr_done (wr_done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_done === 1'b1) done_count++;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) model[i] = 0;
    model[0] = 13;
    model[1] = 25;
    model[2] = 37;
    model[3] = 49;
    err_m = 1'b0;
  endfunction

  // Returns 1 and updates the table when the record is well-formed.
  function automatic bit model_record(input int i, input int h, input int l);
    if (i < N && h < (1 << (D - 8))) begin
      model[i] = h * 256 + l;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int wait_count;
    repeat (gap) begin
      ld.valid = 1'b0;
      @(negedge clk);
    end
    ld.valid = 1'b1;
    ld.data  = b;
    wait_count = 0;
    while (ld.ready !== 1'b1 && wait_count < 8) begin
      @(negedge clk);
      wait_count++;
    end
    if (ld.ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: ld_ready=%b required 1", ld.ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ld.ready !== 1'b1 || wr_done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ready=%b wr_done=%b err=%b required 1 0 0", ld.ready, wr_done, err);
    end
    for (int a = 0; a < N; a++) begin
      addr = A'(a);
      #1;
      checks++;
      if (target !== model[a][D-1:0]) begin
        errors++;
        $display("[TB] FAIL reset_image[%0d]: got %0d required %0d", a, target, model[a]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_write();
    $display("[TB] test_basic_write");
    send_byte(8'h05, 0);
    send_byte(8'h0A, 0);
    send_byte(8'hBC, 0);
    addr = 4'd5;
    #1;
    checks++;
    if (ld.ready !== 1'b0 || wr_done !== 1'b1 || target !== model[5][D-1:0]) begin
      errors++;
      $display("[TB] FAIL basic_commit: ready=%b wr_done=%b target=%0h required 0 1 %0h", ld.ready, wr_done, target, model[5]);
    end
    void'(model_record(5, 8'h0A, 8'hBC));
    @(negedge clk);
    ld.valid = 1'b0;
    checks++;
    if (target !== 12'hABC || wr_done !== 1'b0 || ld.ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_after: target=%0h wr_done=%b ready=%b required abc 0 1", target, wr_done, ld.ready);
    end
  endtask

  task automatic test_malformed_idx();
    $display("[TB] test_malformed_idx");
    send_byte(8'h12, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    addr = 4'd2;
    #1;
    checks++;
    if (wr_done !== 1'b0 || target !== 12'd37) begin
      errors++;
      $display("[TB] FAIL bad_idx_commit: wr_done=%b target=%0d required 0 37", wr_done, target);
    end
    err_m = 1'b1;
    @(negedge clk);
    checks++;
    if (err !== err_m || target !== model[2][D-1:0]) begin
      errors++;
      $display("[TB] FAIL bad_idx_after: err=%b target=%0d required %b %0d", err, target, err_m, model[2]);
    end
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h7F, 0);
    void'(model_record(2, 0, 8'h7F));
    @(negedge clk);
    ld.valid = 1'b0;
    checks++;
    if (target !== 12'd127 || err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL good_after_err: target=%0d err=%b required 127 1", target, err);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    err_m = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_err: err=%b required 0", err);
    end
  endtask

  task automatic test_malformed_hi();
    $display("[TB] test_malformed_hi");
    send_byte(8'h03, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    ld.valid = 1'b0;
    addr = 4'd3;
    clr_err = 1'b1;
    #1;
    checks++;
    if (wr_done !== 1'b0 || target !== 12'd49) begin
      errors++;
      $display("[TB] FAIL bad_hi_commit: wr_done=%b target=%0d required 0 49", wr_done, target);
    end
    @(negedge clk);
    clr_err = 1'b0;
    err_m = 1'b1;
    checks++;
    if (err !== 1'b1 || target !== 12'd49) begin
      errors++;
      $display("[TB] FAIL bad_hi_set_wins: err=%b target=%0d required 1 49", err, target);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    err_m = 1'b0;
  endtask

  task automatic test_gaps();
    $display("[TB] test_gaps");
    done_count = 0;
    send_byte(8'h0F, $urandom_range(1, 4));
    send_byte(8'h0F, $urandom_range(1, 4));
    send_byte(8'hFF, $urandom_range(1, 4));
    ld.valid = 1'b0;
    void'(model_record(15, 8'h0F, 8'hFF));
    repeat (4) @(negedge clk);
    addr = 4'd15;
    #1;
    checks++;
    if (target !== 12'hFFF || done_count != 1) begin
      errors++;
      $display("[TB] FAIL gaps: target=%0h pulses=%0d required fff 1", target, done_count);
    end
  endtask

  task automatic test_reset_mid();
    $display("[TB] test_reset_mid");
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h55, 0);
    void'(model_record(1, 0, 8'h55));
    @(negedge clk);
    addr = 4'd1;
    #1;
    checks++;
    if (target !== 12'h055) begin
      errors++;
      $display("[TB] FAIL pre_reset_write: target=%0h required 055", target);
    end
    send_byte(8'h01, 0);
    ld.valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (target !== 12'd25 || err !== 1'b0 || ld.ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset: target=%0d err=%b ready=%b required 25 0 1", target, err, ld.ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h07, 0);
    send_byte(8'h01, 0);
    send_byte(8'h23, 0);
    ld.valid = 1'b0;
    checks++;
    if (wr_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fresh_commit: wr_done=%b required 1", wr_done);
    end
    void'(model_record(7, 1, 8'h23));
    @(negedge clk);
    addr = 4'd7;
    #1;
    checks++;
    if (target !== model[7][D-1:0]) begin
      errors++;
      $display("[TB] FAIL fresh_write: target=%0h required %0h", target, model[7]);
    end
    // Reset landing inside a commit cycle, with the error flag already up.
    send_byte(8'h1F, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    send_byte(8'h04, 0);
    send_byte(8'h0F, 0);
    send_byte(8'h00, 0);
    ld.valid = 1'b0;
    checks++;
    if (wr_done !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_commit_reset: wr_done=%b err=%b required 1 1", wr_done, err);
    end
    rst_n = 1'b0;
    model_reset();
    addr = 4'd4;
    #1;
    checks++;
    if (wr_done !== 1'b0 || err !== 1'b0 || ld.ready !== 1'b1 || target !== 12'd0) begin
      errors++;
      $display("[TB] FAIL commit_reset: wr_done=%b err=%b ready=%b target=%0h required 0 0 1 0", wr_done, err, ld.ready, target);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int i, h, l, probe;
    bit well, clr;
    int unsigned old;
    $display("[TB] test_random");
    for (int r = 0; r < 40; r++) begin
      i = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      h = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 255));
      send_byte(8'(i), $urandom_range(0, 2));
      send_byte(8'(h), $urandom_range(0, 2));
      send_byte(8'(l), $urandom_range(0, 2));
      addr = 4'(i);
      clr = ($urandom_range(0, 3) == 0);
      clr_err = clr;
      #1;
      old = model[i % N];
      well = model_record(i, h, l);
      checks++;
      if (ld.ready !== 1'b0 || wr_done !== well || target !== old[D-1:0]) begin
        errors++;
        $display("[TB] FAIL rand_commit[%0d]: ready=%b wr_done=%b target=%0h required 0 %b %0h", r, ld.ready, wr_done, target, well, old);
      end
      if (!well) err_m = 1'b1;
      else if (clr) err_m = 1'b0;
      @(negedge clk);
      clr_err = 1'b0;
      checks++;
      if (target !== model[i % N][D-1:0] || err !== err_m) begin
        errors++;
        $display("[TB] FAIL rand_after[%0d]: target=%0h err=%b required %0h %b", r, target, err, model[i % N], err_m);
      end
      probe = int'($urandom_range(0, N - 1));
      addr = 4'(probe);
      #1;
      checks++;
      if (target !== model[probe][D-1:0]) begin
        errors++;
        $display("[TB] FAIL rand_probe[%0d]: target=%0h required %0h", probe, target, model[probe]);
      end
    end
    ld.valid = 1'b0;
  endtask

  initial begin
    ld.valid = 1'b0;
    ld.data  = 8'h00;
    model_reset();
    test_reset();
    test_basic_write();
    test_malformed_idx();
    test_malformed_hi();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_lut_writer.md
# pc_lut_writer

Programmable jump-target table with a byte-stream loader. It holds 2**A entries of D-bit branch targets. A valid/ready byte stream writes the entries, and a combinational read port maps a 4-bit jump index to its target for the fetch unit. The block sits between the boot/debug loader and the program counter, so jump targets can be reprogrammed without resynthesis.

## Interface
Parameters:
- D, 12: target width in bits (9..16).
- A, 4: index width; the table has 2**A entries.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Ld_valid  in  1  loader byte valid.
- Ld_data  in  8  loader byte.
- Ld_ready  out  1  block can accept a byte this cycle.
- Clr_err  in  1  synchronous clear of Err.
- Addr  in  A  read index.
- Target  out  D  table entry at Addr (combinational).
- Wr_done  out  1  one-cycle pulse in the cycle an entry commits.
- Err  out  1  sticky malformed-record flag.

## Operation
- A byte transfers when Ld_valid && Ld_ready on a rising edge.
- A record is exactly three bytes: index, target high, target low.
  - Index byte: bits [A-1:0] are the index. Bits [7:A] must be 0.
  - High byte: bits [D-9:0] are target[D-1:8]. Bits [7:D-8] must be 0.
  - Low byte: target[7:0].
- FSM states and transitions:
  - IDX: on transfer, capture index and go to HI.
  - HI: on transfer, capture the high bits and go to LO.
  - LO: on transfer, capture the low byte and go to COMMIT.
  - COMMIT: Ld_ready=0. If the record is well-formed, write the table and pulse Wr_done. Always return to IDX.
- Malformed record (any must-be-zero bit set in the index or high byte):
  - The record is still consumed in full, keeping framing aligned.
  - The table is not written and Wr_done stays 0.
  - Err sets in the COMMIT cycle.
- Err:
  - Sticky until a cycle with Clr_err=1 and no new error.
  - If an error and Clr_err occur in the same COMMIT cycle, Err ends up 1 (set wins).
- Ld_ready is 1 in IDX, HI and LO, and 0 in COMMIT.
- Holding Ld_valid=0 in any state keeps that state indefinitely; there is no timeout.
- Read port: Target = table[Addr], purely combinational from the table registers.
- Power-on image (after reset):
  - entry 0 = 13, entry 1 = 25, entry 2 = 37, entry 3 = 49.
  - All other entries = 0.
- Arithmetic: targets are stored as-is, with no sign extension. Offset interpretation belongs to the PC logic.

## Timing
- Reset values:
  - FSM in IDX, Ld_ready=1, Wr_done=0, Err=0.
  - Table holds the power-on image.
  - Target reflects the image at Addr.
- Latency: LO byte accepted at edge t → COMMIT during cycle t..t+1 → table written at edge t+1 → new value on Target from t+1 onward.
- Throughput: one record per 4 cycles maximum (3 transfers + 1 commit).
- Read during commit: a read of the committing index in the COMMIT cycle returns the old value; the new value appears after the edge. There is no bypass.
- Reset asserted mid-record, including during COMMIT:
  - Partial record discarded and FSM forced to IDX asynchronously.
  - Table restored to the power-on image.
  - Err cleared and Wr_done deasserted immediately.
- Rewriting the same index twice: the last commit wins.

## Structure
- Package pc_lut_pkg holds:
  - FSM state enum (IDX, HI, LO, COMMIT);
  - default D and A;
  - power-on image as a localparam array indexed by entry.
- pc_lut_writer reads its default image from the package.
- One sub-module is natural: pc_lut_regfile.
  - Contents: 2**A × D registers, one write port (we, waddr, wdata), combinational read, async reset to the image.
  - pc_lut_writer instantiates it and owns the FSM, byte assembly and error checking.

## Test plan
- Reset, then sweep Addr 0..15 → Target = 13, 25, 37, 49, then 0 for indices 4..15.
- Stream bytes 0x05, 0x0A, 0xBC with Ld_valid held high → Ld_ready low one cycle, Wr_done pulses once, Target at Addr=5 reads 0xABC from the next cycle. Addr=5 during the COMMIT cycle reads 0.
- Stream 0x12, 0x01, 0x00 (index byte has bit 4 set) → no write, Err=1, entry 2 still 37. Then 0x02, 0x00, 0x7F → entry 2 = 127 and Err stays 1. Pulse Clr_err → Err=0.
- Stream 0x03, 0x10, 0x00 (high-byte bit 4 set with D=12) → Err=1, entry 3 still 49.
- Insert random Ld_valid gaps between the three bytes of record 0x0F, 0x0F, 0xFF → entry 15 = 0xFFF, exactly one Wr_done.
- Write 0x01, 0x00, 0x55, then assert Rst_n=0 after only the index byte of a second record → entry 1 back to 25, FSM in IDX. A fresh record after reset is accepted correctly.
